// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter driven by an external baud tick.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   tx_data, tx_valid    word to send and its valid strobe
//   tx_ready             word accepted on an edge where tx_valid && tx_ready
//   parity_en/_odd       parity enable and odd/even select, captured per frame
//   baud_tick            one-cycle pulse ending each bit period
//   baud_en              runs the baud counter while a frame is in flight
//   tx, busy, tx_done    serial line, frame in progress, end-of-frame pulse
module uart_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              baud_tick,
    output logic              baud_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    localparam int IW = $clog2(DATA_W);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              par_en_q, par_en_d;
    logic              par_q, par_d;
    logic              stop_q, stop_d;
    logic              done_q, done_d;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                shift_d  = tx_data;
                idx_d    = '0;
                stop_d   = 1'b0;
                par_en_d = parity_en;
                // parity bit is fixed at capture so later input changes cannot leak in
                par_d    = ^tx_data ^ parity_odd;
                state_d  = START;
            end
            START: if (baud_tick) state_d = DATA;
            DATA: if (baud_tick) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (baud_tick) state_d = STOP;
            STOP: if (baud_tick) begin
                stop_d = stop_q + 1'b1;
                if (stop_q == 1'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign tx_ready = state_q == IDLE;
    assign busy     = !tx_ready;
    assign baud_en  = busy;
    assign tx_done  = done_q;
    assign tx = state_q == START  ? 1'b0 :
                state_q == DATA   ? shift_q[0] :
                state_q == PARITY ? par_q : 1'b1;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx (1 and 2 stop bits).
module tb_uart_tx;
    localparam int P = 20;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [1:0] valid = 2'b00;
    logic [1:0] ftick = 2'b00;
    logic [1:0] rdy, en, txw, busy, done, tick;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : bc
        int cnt = 0;
        always @(posedge clk) cnt <= (!en[g] || cnt == P - 1) ? 0 : cnt + 1;
        assign tick[g] = (en[g] && cnt == P - 1) || ftick[g];
    end
    uart_tx #(.DATA_W(8), .STOP_BITS(1)) u0 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[0]), .tx_ready(rdy[0]),
        .parity_en(parity_en), .parity_odd(parity_odd), .baud_tick(tick[0]), .baud_en(en[0]),
        .tx(txw[0]), .busy(busy[0]), .tx_done(done[0])
    );
    uart_tx #(.DATA_W(8), .STOP_BITS(2)) u1 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(valid[1]), .tx_ready(rdy[1]),
        .parity_en(parity_en), .parity_odd(parity_odd), .baud_tick(tick[1]), .baud_en(en[1]),
        .tx(txw[1]), .busy(busy[1]), .tx_done(done[1])
    );

    // Sends one frame on DUT s and checks every bit period against the expected
    // frame {start, data LSB first, parity, stop...}. With hold the source keeps
    // tx_valid high and presents nxt mid-frame; abort >= 0 resets at that offset.
    task automatic send(input int s, input logic [7:0] d, input logic pen, input logic podd,
                        input logic hold, input logic [7:0] nxt, input int abort);
        logic exp[$];
        int n;
        @(negedge clk);
        tx_data = d;
        parity_en = pen;
        parity_odd = podd;
        valid[s] = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!busy[s] && n < 100);
        checks++;
        if (!busy[s]) begin
            errors++;
            $display("FAIL accept dut%0d: busy=%b required 1 within 100 cycles", s, busy[s]);
            valid[s] = 1'b0;
            return;
        end
        valid[s] = hold;
        tx_data = hold ? nxt : 8'($urandom);
        if (!hold) begin
            parity_en = 1'($urandom);
            parity_odd = 1'($urandom);
        end
        exp = {};
        exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp.push_back(d[i]);
        if (pen) exp.push_back(^d ^ podd);
        for (int i = 0; i <= s; i++) exp.push_back(1'b1);
        for (int c = 0; c < exp.size() * P; c++) begin
            if (c == abort) begin
                rstn = 1'b0;
                #1;
                checks++;
                if ({txw[s], rdy[s], en[s], busy[s], done[s]} !== 5'b11000) begin
                    errors++;
                    $display("FAIL async_reset dut%0d: tx,rdy,en,busy,done=%b required 11000",
                             s, {txw[s], rdy[s], en[s], busy[s], done[s]});
                end
                repeat (2) @(posedge clk);
                #1;
                checks++;
                if ({txw[s], done[s]} !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d: tx,done=%b required 10", s, {txw[s], done[s]});
                end
                rstn = 1'b1;
                return;
            end
            if (c % P == P / 2) begin
                checks++;
                if (txw[s] !== exp[c / P]) begin
                    errors++;
                    $display("FAIL bit%0d dut%0d data=%h: tx=%b required %b", c / P, s, d, txw[s], exp[c / P]);
                end
            end
            checks++;
            if ({rdy[s], en[s], busy[s], done[s]} !== 4'b0110) begin
                errors++;
                $display("FAIL in_frame dut%0d cycle %0d: rdy,en,busy,done=%b required 0110",
                         s, c, {rdy[s], en[s], busy[s], done[s]});
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({rdy[s], en[s], busy[s], done[s], txw[s]} !== 5'b10011) begin
            errors++;
            $display("FAIL frame_end dut%0d after %0d ticks: rdy,en,busy,done,tx=%b required 10011",
                     s, exp.size(), {rdy[s], en[s], busy[s], done[s], txw[s]});
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            checks++;
            if (done[s] !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse dut%0d: tx_done=%b required 0", s, done[s]);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({txw[s], rdy[s], en[s], busy[s], done[s]} !== 5'b11000) begin
                errors++;
                $display("FAIL reset dut%0d: tx,rdy,en,busy,done=%b required 11000",
                         s, {txw[s], rdy[s], en[s], busy[s], done[s]});
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        ftick = 2'b11;
        @(negedge clk);
        ftick = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({txw[s], rdy[s], busy[s], done[s]} !== 4'b1100) begin
                errors++;
                $display("FAIL idle_tick dut%0d: tx,rdy,busy,done=%b required 1100",
                         s, {txw[s], rdy[s], busy[s], done[s]});
            end
        end
    endtask

    task automatic test_no_parity();
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    endtask

    task automatic test_parity();
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, -1);
        send(0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, -1);
    endtask

    task automatic test_two_stop();
        send(1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    endtask

    task automatic test_back_to_back();
        send(0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hC3, -1);
        send(0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    endtask

    task automatic test_reset_mid();
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 4 * P + P / 2);
        send(0, 8'h96, 1'b1, 1'b1, 1'b0, 8'h00, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            send(int'($urandom_range(1)), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, -1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that consumes the single-cycle bit-period tick (`baud_clk`) produced by `baud_counter`. It also drives that counter's `en` input.
- Accepts one parallel word per valid/ready handshake.
- Serialises it LSB-first as start, data, optional parity, then stop bit(s) on `tx`.
- Gates the baud counter so ticks run only while a frame is in flight.

Parameters:
- DATA_W, 8, number of data bits per frame (5..9).
- STOP_BITS, 1, number of stop-bit periods (1 or 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- parity_en  input  1  append a parity bit when 1.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- baud_tick  input  1  one-cycle pulse marking the end of each bit period (connects to baud_counter baud_clk).
- baud_en  output  1  enables the baud counter (connects to baud_counter en).
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, tx=1, tx_ready=1, baud_en=0, busy=0, tx_done=0.
  - Shift register and counters are cleared.
  - Outputs take these values immediately, not at the next edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, baud_en=0, busy=0.
  - On clk edge with tx_valid && tx_ready: capture tx_data, parity_en and parity_odd into internal registers, then go to START.
  - baud_tick is ignored in IDLE.
- START: tx=0, baud_en=1, busy=1, tx_ready=0. On baud_tick: go to DATA with bit index 0.
- DATA:
  - tx = captured bit[idx], LSB first.
  - On baud_tick: idx+1. At idx=DATA_W-1 go to PARITY if parity was enabled, else STOP.
- PARITY:
  - tx = XOR of captured data bits, XOR captured parity_odd. Even parity gives an even total count of ones across data+parity.
  - On baud_tick: go to STOP.
- STOP:
  - tx=1. Counts STOP_BITS ticks.
  - On the last tick: tx_done=1 for that same edge's following cycle only, state=IDLE, baud_en=0.
- Bit timing: each bit holds on tx for exactly one tick interval. The tx transition occurs on the clk edge where baud_tick=1 is sampled.
- baud_en timing:
  - baud_en asserts on the edge that accepts a word.
  - The baud counter restarts its count when en rises, so the start bit lasts one full period.
- Back-to-back frames: tx_ready is low from acceptance until IDLE is re-entered. Minimum gap is one idle clk at tx=1 between the stop bit and the next start bit.
- Input changes mid-frame:
  - Changes to tx_data/parity inputs while busy have no effect on the frame.
  - tx_valid while busy is not accepted; the source holds it until tx_ready.
- Frame length: 1+DATA_W+parity+STOP_BITS ticks. tx_done fires after tick number 1+DATA_W+parity+STOP_BITS from acceptance.
- Reset mid-frame: frame is abandoned, tx returns high at once, baud_en drops, no tx_done.

Test Plan:
- Reset values: hold rstn=0 for 2 cycles -> tx=1, tx_ready=1, baud_en=0, busy=0, tx_done=0. Pulse baud_tick in IDLE -> no state change.
- No-parity frame: DATA_W=8, STOP_BITS=1, parity_en=0, send 0xA5 with tick every 20 clk.
  - tx per bit period = 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once after the 10th tick; baud_en low afterwards.
- Parity frames: send 0xA5 with parity_en=1.
  - parity_odd=0 -> parity bit 0.
  - parity_odd=1 -> parity bit 1.
  - Frame is 11 ticks in both cases.
- Two stop bits: STOP_BITS=2, send 0x00 -> tx = 0, then eight 0s, then 1,1. tx_done after the 11th tick.
- Back-to-back with input changes: hold tx_valid=1 with 0x3C then 0xC3, changing tx_data mid-frame.
  - Each frame matches the data captured at its accept.
  - tx_ready is low throughout each frame.
  - At least one idle-high cycle between frames.
- Reset mid-frame: assert rstn=0 during the DATA bit 3 period -> tx=1 and baud_en=0 asynchronously, no tx_done. After release, tx_ready=1 and a new frame transmits correctly.
